// File: rtl/text_cmd_engine.sv
// Text-mode command engine: CPU register file plus executor that writes {attr, char}
// cells into text VRAM through a request/ack write port.
module text_cmd_engine #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int ATTR_W  = 8,
    parameter int VADDR_W = 12
) (
    input  logic                  cpu_clock,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  rw,
    input  logic [3:0]            addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    output logic                  vram_we,
    output logic [VADDR_W-1:0]    vram_addr,
    output logic [8+ATTR_W-1:0]   vram_wdata,
    input  logic                  vram_ack,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL} state_t;

    localparam logic [VADDR_W-1:0] COLS_A    = VADDR_W'(COLS);
    localparam logic [VADDR_W-1:0] ROW_SPAN  = VADDR_W'(COLS - 1);
    localparam logic [VADDR_W-1:0] LAST_CELL = VADDR_W'(COLS * ROWS - 1);

    state_t                state_q, state_d;
    logic [7:0]            arg0_q, arg0_d, arg1_q, arg1_d, arg2_q, arg2_d, arg3_q, arg3_d;
    logic [7:0]            cur_row_q, cur_row_d, cur_col_q, cur_col_d;
    logic [7:0]            pend_row_q, pend_row_d, pend_col_q, pend_col_d;
    logic                  err_q, err_d, we_q, we_d, busy_q, busy_d;
    logic [VADDR_W-1:0]    vaddr_q, vaddr_d, last_q, last_d;
    logic [8+ATTR_W-1:0]   wdata_q, wdata_d;

    logic                  cmd_wr, arg_row_bad, arg_col_bad;
    logic [VADDR_W-1:0]    arg_base, arg_cell, cur_cell;
    logic [8+ATTR_W-1:0]   cell_data;
    logic [15:0]           arg_next, cur_next;

    // Position following (r, c) in raster order, wrapping bottom-right to top-left.
    function automatic logic [15:0] advance(input logic [7:0] r, input logic [7:0] c);
        if (32'(c) >= COLS - 1)
            return {((32'(r) >= ROWS - 1) ? 8'd0 : r + 8'd1), 8'd0};
        return {r, c + 8'd1};
    endfunction

    always_comb begin
        cmd_wr      = ce & rw & (addr == 4'd0);
        arg_row_bad = 32'(arg2_q) >= ROWS;
        arg_col_bad = 32'(arg3_q) >= COLS;
        arg_base    = VADDR_W'(arg2_q) * COLS_A;
        arg_cell    = arg_base + VADDR_W'(arg3_q);
        cur_cell    = VADDR_W'(cur_row_q) * COLS_A + VADDR_W'(cur_col_q);
        cell_data   = {ATTR_W'(arg1_q), arg0_q};
        arg_next    = advance(arg2_q, arg3_q);
        cur_next    = advance(cur_row_q, cur_col_q);
    end

    always_comb begin
        state_d    = state_q;
        arg0_d     = arg0_q;
        arg1_d     = arg1_q;
        arg2_d     = arg2_q;
        arg3_d     = arg3_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        pend_row_d = pend_row_q;
        pend_col_d = pend_col_q;
        err_d      = err_q;
        we_d       = we_q;
        busy_d     = busy_q;
        vaddr_d    = vaddr_q;
        last_d     = last_q;
        wdata_d    = wdata_q;

        if (ce & rw) begin
            case (addr)
                4'd1:    arg0_d = data_in;
                4'd2:    arg1_d = data_in;
                4'd3:    arg2_d = data_in;
                4'd4:    arg3_d = data_in;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_wr) begin
                    // Commands use the argument values held before this cycle's write.
                    case (data_in[2:0])
                        3'd0: begin
                            if (arg_row_bad || arg_col_bad) begin
                                err_d = 1'b1;
                            end else begin
                                state_d    = S_WRITE;
                                we_d       = 1'b1;
                                busy_d     = 1'b1;
                                vaddr_d    = arg_cell;
                                wdata_d    = cell_data;
                                pend_row_d = arg_next[15:8];
                                pend_col_d = arg_next[7:0];
                            end
                        end
                        3'd1: begin
                            if (arg_row_bad || arg_col_bad) begin
                                err_d = 1'b1;
                            end else begin
                                cur_row_d = arg2_q;
                                cur_col_d = arg3_q;
                            end
                        end
                        3'd2: begin
                            state_d    = S_WRITE;
                            we_d       = 1'b1;
                            busy_d     = 1'b1;
                            vaddr_d    = cur_cell;
                            wdata_d    = cell_data;
                            pend_row_d = cur_next[15:8];
                            pend_col_d = cur_next[7:0];
                        end
                        3'd3: begin
                            state_d = S_FILL;
                            we_d    = 1'b1;
                            busy_d  = 1'b1;
                            vaddr_d = '0;
                            last_d  = LAST_CELL;
                            wdata_d = cell_data;
                        end
                        3'd4: begin
                            if (arg_row_bad) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = S_FILL;
                                we_d    = 1'b1;
                                busy_d  = 1'b1;
                                vaddr_d = arg_base;
                                last_d  = arg_base + ROW_SPAN;
                                wdata_d = cell_data;
                            end
                        end
                        3'd7:    err_d = 1'b0;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_WRITE: begin
                if (cmd_wr)
                    err_d = 1'b1;
                if (vram_ack) begin
                    state_d   = S_IDLE;
                    we_d      = 1'b0;
                    busy_d    = 1'b0;
                    cur_row_d = pend_row_q;
                    cur_col_d = pend_col_q;
                end
            end
            S_FILL: begin
                if (cmd_wr)
                    err_d = 1'b1;
                if (vram_ack) begin
                    if (vaddr_q == last_q) begin
                        state_d = S_IDLE;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        vaddr_d = vaddr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            arg0_q     <= '0;
            arg1_q     <= '0;
            arg2_q     <= '0;
            arg3_q     <= '0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            pend_row_q <= '0;
            pend_col_q <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            vaddr_q    <= '0;
            last_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            arg0_q     <= arg0_d;
            arg1_q     <= arg1_d;
            arg2_q     <= arg2_d;
            arg3_q     <= arg3_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            pend_row_q <= pend_row_d;
            pend_col_q <= pend_col_d;
            err_q      <= err_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            vaddr_q    <= vaddr_d;
            last_q     <= last_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (ce & ~rw) begin
            case (addr)
                4'd1:    data_out = arg0_q;
                4'd2:    data_out = arg1_q;
                4'd3:    data_out = arg2_q;
                4'd4:    data_out = arg3_q;
                4'd5:    data_out = {6'b0, err_q, busy_q};
                4'd6:    data_out = cur_row_q;
                4'd7:    data_out = cur_col_q;
                default: data_out = 8'h00;
            endcase
        end
    end

    assign data_oe    = ce & ~rw;
    assign vram_we    = we_q;
    assign vram_addr  = vaddr_q;
    assign vram_wdata = wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_text_cmd_engine.sv
// Bench for text_cmd_engine: a cell-level model predicts every VRAM write, cursor and
// status; a negedge monitor compares the write port and busy against it each cycle.
module tb_text_cmd_engine;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        rw = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [7:0]  data_in = 8'd0;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic [15:0] vram_wdata;
    logic        vram_ack = 1'b1;
    logic        busy;

    text_cmd_engine #(.COLS(COLS), .ROWS(ROWS), .ATTR_W(8), .VADDR_W(12)) dut (
        .cpu_clock (clk),
        .reset     (reset),
        .ce        (ce),
        .rw        (rw),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_wdata(vram_wdata),
        .vram_ack  (vram_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [7:0]  m_arg [1:4];
    int          m_row, m_col;
    logic        m_err;
    int          exp_addr [$];
    logic [15:0] exp_data [$];

    // Write log filled by the monitor
    int          wr_count;
    int          first_addr, last_addr;
    logic [15:0] last_data;

    int ack_mode = 0;   // 0: ack held high, 1: ack toggles every cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 4; i++) m_arg[i] = 8'h00;
        m_row = 0;
        m_col = 0;
        m_err = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic clear_log();
        wr_count   = 0;
        first_addr = -1;
        last_addr  = -1;
        last_data  = 16'h0;
    endtask

    task automatic push_cell(input int a);
        exp_addr.push_back(a);
        exp_data.push_back({m_arg[2], m_arg[1]});
    endtask

    // Cursor advance expressed as raster index + 1 modulo screen size.
    task automatic model_advance(input int r, input int c);
        int idx;
        idx   = (r * COLS + c + 1) % CELLS;
        m_row = idx / COLS;
        m_col = idx % COLS;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 1) vram_ack = ~vram_ack;
            else               vram_ack = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", {31'b0, busy}, {31'b0, exp_addr.size() != 0});
            chk("vram_we", {31'b0, vram_we}, {31'b0, exp_addr.size() != 0});
            chk("data_oe", {31'b0, data_oe}, {31'b0, ce & ~rw});
            if (!ce) chk("data_out_idle", {24'b0, data_out}, 32'h0);
            if (vram_we && exp_addr.size() != 0) begin
                chk("vram_addr", {20'b0, vram_addr}, exp_addr[0]);
                chk("vram_wdata", {16'b0, vram_wdata}, {16'b0, exp_data[0]});
                if (vram_ack) begin
                    if (wr_count == 0) first_addr = int'(vram_addr);
                    last_addr = int'(vram_addr);
                    last_data = vram_wdata;
                    wr_count++;
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                end
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        ce = 1'b1; rw = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1;
        ce = 1'b0; rw = 1'b0;
        if (a >= 4'd1 && a <= 4'd4) m_arg[a] = d;
    endtask

    task automatic do_cmd(input logic [2:0] c);
        bit busy_snap;
        int r, col;
        @(posedge clk);
        #1;
        busy_snap = exp_addr.size() != 0;
        ce = 1'b1; rw = 1'b1; addr = 4'd0; data_in = {5'b0, c};
        @(posedge clk);
        #1;
        ce = 1'b0; rw = 1'b0;
        r   = int'(m_arg[3]);
        col = int'(m_arg[4]);
        $display("cmd %0d issued (arg row=%0d col=%0d char=%02h attr=%02h)", c, r, col, m_arg[1], m_arg[2]);
        if (busy_snap) begin
            m_err = 1'b1;
        end else begin
            case (c)
                3'd0: if (r >= ROWS || col >= COLS) m_err = 1'b1;
                      else begin push_cell(r * COLS + col); model_advance(r, col); end
                3'd1: if (r >= ROWS || col >= COLS) m_err = 1'b1;
                      else begin m_row = r; m_col = col; end
                3'd2: begin push_cell(m_row * COLS + m_col); model_advance(m_row, m_col); end
                3'd3: for (int i = 0; i < CELLS; i++) push_cell(i);
                3'd4: if (r >= ROWS) m_err = 1'b1;
                      else for (int i = 0; i < COLS; i++) push_cell(r * COLS + i);
                3'd7: m_err = 1'b0;
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic cpu_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(posedge clk);
        #1;
        ce = 1'b1; rw = 1'b0; addr = a;
        @(negedge clk);
        chk(name, {24'b0, data_out}, {24'b0, exp});
        $display("read addr %0d -> %02h (expect %02h)", a, data_out, exp);
        @(posedge clk);
        #1;
        ce = 1'b0;
    endtask

    task automatic check_model_regs();
        cpu_read(4'd5, {6'b0, m_err, 1'b0}, "status");
        cpu_read(4'd6, m_row[7:0], "cursor_row");
        cpu_read(4'd7, m_col[7:0], "cursor_col");
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((exp_addr.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            errors++;
            checks++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic wait_writes(input int count, input int budget, input string name);
        int n = 0;
        while (wr_count < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            errors++;
            checks++;
            $display("FAIL %s: saw %0d writes, required %0d", name, wr_count, count);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_log();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'b0, vram_we}, 32'h0);
        chk("rst_addr", {20'b0, vram_addr}, 32'h0);
        chk("rst_wdata", {16'b0, vram_wdata}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_dout", {24'b0, data_out}, 32'h0);
        reset = 1'b0;

        // WRITE_AT (1,0)
        cpu_write(4'd1, 8'hB0);
        cpu_write(4'd2, 8'h0F);
        cpu_write(4'd3, 8'd1);
        cpu_write(4'd4, 8'd0);
        clear_log();
        do_cmd(3'd0);
        wait_idle(20, "write_at_done");
        chk("wa_count", wr_count, 1);
        chk("wa_addr", last_addr, 80);
        chk("wa_data", {16'b0, last_data}, 32'h0FB0);
        cpu_read(4'd6, 8'd1, "wa_cur_row");
        cpu_read(4'd7, 8'd1, "wa_cur_col");
        cpu_read(4'd5, 8'h00, "wa_status");
        cpu_read(4'd1, 8'hB0, "arg0_read");

        // SET_CURSOR (29,79), then two PUTs wrapping the screen
        cpu_write(4'd3, 8'd29);
        cpu_write(4'd4, 8'd79);
        do_cmd(3'd1);
        check_model_regs();
        cpu_write(4'd1, 8'h41);
        clear_log();
        do_cmd(3'd2);
        wait_idle(20, "put1_done");
        chk("put1_addr", last_addr, 2399);
        chk("put1_data", {16'b0, last_data}, 32'h0F41);
        cpu_write(4'd1, 8'h42);
        clear_log();
        do_cmd(3'd2);
        wait_idle(20, "put2_done");
        chk("put2_addr", last_addr, 0);
        chk("put2_data", {16'b0, last_data}, 32'h0F42);
        cpu_read(4'd6, 8'd0, "put_cur_row");
        cpu_read(4'd7, 8'd1, "put_cur_col");

        // FILL_SCREEN with ack held high
        cpu_write(4'd1, 8'h20);
        cpu_write(4'd2, 8'h07);
        clear_log();
        do_cmd(3'd3);
        wait_idle(3000, "fill1_done");
        chk("fill1_count", wr_count, 2400);
        chk("fill1_first", first_addr, 0);
        chk("fill1_last", last_addr, 2399);
        chk("fill1_data", {16'b0, last_data}, 32'h0720);

        // FILL_SCREEN with toggling ack; CMD during fill is rejected
        ack_mode = 1;
        clear_log();
        do_cmd(3'd3);
        repeat (40) @(posedge clk);
        do_cmd(3'd0);
        cpu_read(4'd5, 8'h03, "fill_busy_status");
        wait_idle(6000, "fill2_done");
        chk("fill2_count", wr_count, 2400);
        chk("fill2_last", last_addr, 2399);
        ack_mode = 0;
        cpu_read(4'd5, 8'h02, "fill2_err_status");
        do_cmd(3'd7);
        cpu_read(4'd5, 8'h00, "clr_err_status");

        // Out-of-range WRITE_AT, unused opcodes
        cpu_write(4'd3, 8'd30);
        cpu_write(4'd4, 8'd5);
        clear_log();
        do_cmd(3'd0);
        repeat (5) @(posedge clk);
        chk("oor_count", wr_count, 0);
        check_model_regs();
        do_cmd(3'd7);
        do_cmd(3'd5);
        cpu_read(4'd5, 8'h02, "op5_status");
        do_cmd(3'd7);
        do_cmd(3'd6);
        cpu_read(4'd5, 8'h02, "op6_status");
        do_cmd(3'd7);
        cpu_write(4'd3, 8'd30);
        do_cmd(3'd4);
        cpu_read(4'd5, 8'h02, "row_oor_status");
        do_cmd(3'd7);

        // FILL_ROW 2
        cpu_write(4'd3, 8'd2);
        clear_log();
        do_cmd(3'd4);
        wait_idle(200, "fill_row_done");
        chk("row_count", wr_count, 80);
        chk("row_first", first_addr, 160);
        chk("row_last", last_addr, 239);
        check_model_regs();

        // Reset halfway through FILL_SCREEN
        clear_log();
        do_cmd(3'd3);
        wait_writes(1200, 2000, "mid_fill_progress");
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("abort_we", {31'b0, vram_we}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_model_regs();
        cpu_write(4'd1, 8'h2E);
        cpu_write(4'd2, 8'h1E);
        clear_log();
        do_cmd(3'd3);
        wait_writes(5, 50, "refill_start");
        chk("refill_first", first_addr, 0);
        wait_idle(3000, "refill_done");
        chk("refill_count", wr_count, 2400);
        chk("refill_data", {16'b0, last_data}, 32'h1E2E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
